// File: rtl/toggle_pkg.sv
// Shared types and default sizing for the toggle-coded event decoder.
package toggle_pkg;

  typedef enum logic {PRIME, RUN} state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_CNT_W       = 8;

  // Largest value the pending counter can hold before events are lost.
  function automatic int max_pend(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain
  import toggle_pkg::*;
#(
  parameter int N = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_reg;
  logic [N-1:0] stage_next;

  assign stage_next = {stage_reg[N-2:0], d};
  assign q          = stage_reg[N-1];

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_reg[gi] <= 1'b0;
      else     stage_reg[gi] <= stage_next[gi];
    end
  end

endmodule

// File: rtl/toggle_event_decoder.sv
// Recovers one event per level change of a remote toggle line, buffers them
// for a valid/ready consumer and keeps a wrapping total and a sticky overflow.
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_in,
  input  logic              en,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              overflow,
  output logic              q_mirror,
  output logic              qb_mirror
);

  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(max_pend(PEND_W));
  localparam logic [2:0]        PRIME_LAST = 3'(SYNC_STAGES);

  logic   t_sync;
  state_t state_reg;
  logic [2:0] prime_reg;
  logic   prev_reg;
  logic   edge_det;
  logic   event_hit;
  logic   consume;
  logic   pend_full;

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (t_in),
    .q   (t_sync)
  );

  assign edge_det  = t_sync ^ prev_reg;
  assign event_hit = (state_reg == RUN) && edge_det && en;
  assign evt_valid = (pend_cnt != '0);
  assign consume   = evt_valid && evt_ready;
  assign pend_full = (pend_cnt == PEND_FULL);
  assign q_mirror  = prev_reg;
  assign qb_mirror = ~prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= PRIME;
      prime_reg <= 3'd0;
      prev_reg  <= 1'b0;
      evt_pulse <= 1'b0;
      pend_cnt  <= '0;
      total_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      // prev follows the synchronized line in both states, even with en=0.
      prev_reg  <= t_sync;
      evt_pulse <= event_hit;

      // PRIME lets the chain and prev settle so the reset-release level of
      // t_in is never mistaken for a toggle.
      case (state_reg)
        PRIME: begin
          if (prime_reg == PRIME_LAST) state_reg <= RUN;
          else                         prime_reg <= prime_reg + 3'd1;
        end
        RUN: ;
        default: state_reg <= PRIME;
      endcase

      if (event_hit) total_cnt <= total_cnt + CNT_W'(1);

      if (event_hit && !consume) begin
        if (!pend_full) pend_cnt <= pend_cnt + PEND_W'(1);
      end else if (!event_hit && consume) begin
        pend_cnt <= pend_cnt - PEND_W'(1);
      end

      // A fresh loss outranks a clear request in the same cycle.
      if (event_hit && !consume && pend_full) overflow <= 1'b1;
      else if (clr_ovf)                       overflow <= 1'b0;
    end
  end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive-side decoder for toggle-coded event signalling. A remote T-type flip-flop flips its output once per event; this block recovers those events. It synchronizes the toggle line into the local clock domain and detects each level change as one event. Events are buffered in a pending counter and handed to a consumer over a valid/ready handshake, and the block keeps a free-running total event count and a sticky overflow flag.

## Interface
- SYNC_STAGES, 2, synchronizer flops on t_in (legal 2..4)
- PEND_W, 4, pending-counter width; capacity 2^PEND_W-1 events
- CNT_W, 8, total event counter width

- clk  in  1  rising-edge clock, sole clock
- rst  in  1  reset, asynchronous and active-high
- t_in  in  1  toggle line from remote T flip-flop; asynchronous to clk
- en  in  1  1 = count/buffer events; 0 = events discarded
- evt_ready  in  1  consumer accepts one event
- clr_ovf  in  1  clears overflow
- evt_pulse  out  1  one-cycle pulse per detected toggle (en=1, RUN only)
- evt_valid  out  1  pend_cnt != 0
- pend_cnt  out  PEND_W  events awaiting consumption
- total_cnt  out  CNT_W  accepted-event count, wraps modulo 2^CNT_W
- overflow  out  1  sticky: event lost because pend_cnt was full
- q_mirror  out  1  local copy of remote toggle state (prev register)
- qb_mirror  out  1  ~q_mirror

## Operation
- Reset (async assert) clears: sync chain, prev, evt_pulse, pend_cnt, total_cnt, overflow, to 0; q_mirror 0, qb_mirror 1; state PRIME, prime counter 0.
- FSM, 2 states:
  - PRIME: each edge prev <= sN (last sync stage); no event generated; after SYNC_STAGES+1 edges -> RUN.
  - RUN: edge = sN ^ prev; prev <= sN every edge.
- Priming means t_in at either level at reset release produces no spurious event.
- Event (RUN, edge=1, en=1): evt_pulse <= 1 next edge; total_cnt += 1 (wrap); pend_cnt += 1 unless full.
- Event with en=0: prev still updates, q_mirror tracks; no pulse, no count change.
- Consume: evt_valid && evt_ready decrements pend_cnt. evt_ready with evt_valid=0 has no effect.
- Simultaneous event and consume: pend_cnt unchanged; total_cnt still increments.
- Full (pend_cnt = 2^PEND_W-1) with event and no consume: pend_cnt holds, overflow <= 1, total_cnt still increments, evt_pulse still fires.
- Full with event and consume same cycle: no loss, pend_cnt holds, overflow unaffected.
- clr_ovf clears overflow; a new overflow in the same cycle wins (overflow stays 1).
- Remote toggles faster than one per clock are unsupported; at most one event per clock is detected.

## Timing
- Event latency: t_in changes before sampling edge E0. s1 captures at E0, sN at E(N-1). evt_pulse, prev and counters update at E(N), with N = SYNC_STAGES. Default: outputs change at the 3rd sampling edge.
- evt_pulse is exactly one cycle wide; back-to-back events give back-to-back pulses.
- evt_valid is combinational from pend_cnt, registered-only path. Handshake completes on the edge where evt_valid && evt_ready.
- All outputs are registered except evt_valid and qb_mirror (pure decode of registers).
- Reset mid-operation: pending events and counts are discarded immediately. PRIME restarts on the first edge after deassertion.

## Structure
- Package toggle_pkg: state enum {PRIME, RUN}; default SYNC_STAGES/PEND_W/CNT_W constants; MAX_PEND localparam function.
- Sub-module sync_chain: parameterized N-flop synchronizer with async active-high reset to 0, instantiated once on t_in.
- Top holds the FSM, edge detect, counters and handshake.

## Test plan
- Reset with t_in=1, hold 10 cycles -> no evt_pulse, total_cnt=0, q_mirror=1 after PRIME.
- t_in toggles 6 times, 4 cycles apart, evt_ready=1 -> 6 pulses, each 3 edges after change; total_cnt=6, pend_cnt never exceeds 1.
- evt_ready=0, 17 toggles (PEND_W=4) -> pend_cnt=15, overflow=1, total_cnt=17; then evt_ready=1 for 15 cycles -> pend_cnt=0, evt_valid=0.
- pend_cnt=15, event and evt_ready same cycle -> pend_cnt=15, overflow stays 0; event + clr_ovf when full, no consume -> overflow=1.
- en=0, 3 toggles -> no pulses, counts unchanged, q_mirror follows t_in; en=1, 1 toggle -> total_cnt +1.
- 260 toggles with CNT_W=8, evt_ready=1 -> total_cnt=4. Assert rst mid-stream -> all counters 0 asynchronously, no event for SYNC_STAGES+1 edges after release.
